// File: rtl/fetch_stage.sv
// fetch_stage: IITB-RISC instruction fetch with PC, IF/ID register, stall/flush/redirect and halt
//   clk, rst_n                  clock, synchronous active-low reset
//   imem_addr / imem_data       asynchronous ROM port (data valid in the same cycle)
//   stall, flush                decode-side hold and squash requests
//   redirect_valid, redirect_pc taken branch/jump target
//   ifid_*                      IF/ID register (valid, instruction, its pc, pc+1)
//   halted                      fetch stopped because the PC left the ROM
module fetch_stage #(
    parameter int                PC_WIDTH    = 16,
    parameter int                INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                ROM_DEPTH   = 21
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   ifid_valid,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic [PC_WIDTH-1:0]    ifid_pc_plus1,
    output logic                   halted
);
    typedef enum logic {RUN, HALT} state_t;
    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                valid_d, load;
    logic                in_range;

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);
    assign in_range  = pc_q < PC_WIDTH'(ROM_DEPTH);

    // Priority: redirect > halt > flush > stall > fetch. Flush keeps pc_q so the
    // squashed word is simply fetched again on the next edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = ifid_valid;
        load    = 1'b0;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (state_q == HALT || flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            if (in_range) begin
                load    = 1'b1;
                valid_d = 1'b1;
                pc_d    = pc_q + 1'b1;
            end else begin
                valid_d = 1'b0;
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus1 <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ifid_valid <= valid_d;
            if (load) begin
                ifid_instr    <= imem_data;
                ifid_pc       <= pc_q;
                ifid_pc_plus1 <= pc_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plan plus random stimulus against a behavioural fetch model
module tb_fetch_stage;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [15:0] imem_addr, imem_data;
    logic        stall = 0, flush = 0, redirect_valid = 0;
    logic [15:0] redirect_pc = 0;
    logic        ifid_valid, halted;
    logic [15:0] ifid_instr, ifid_pc, ifid_pc_plus1;

    int n_cmp = 0, n_err = 0;

    logic [15:0] m_pc, m_i, m_p, m_p1;
    logic        m_v, m_halt;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc_plus1(ifid_pc_plus1), .halted(halted)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 16'd21) ? 16'h1000 + imem_addr : 16'hBAD0 ^ imem_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_pc = 0; m_halt = 0; m_v = 0; m_i = 0; m_p = 0; m_p1 = 0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_v = 0; m_halt = 0;
        end else if (m_halt || flush) begin
            m_v = 0;
        end else if (!stall) begin
            if (m_pc < 21) begin
                m_i = 16'h1000 + m_pc; m_p = m_pc; m_p1 = m_pc + 16'd1;
                m_v = 1; m_pc = m_pc + 16'd1;
            end else begin
                m_v = 0; m_halt = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("pc", imem_addr, m_pc);
        chk("halted", halted, m_halt);
        chk("valid", ifid_valid, m_v);
        chk("instr", ifid_instr, m_i);
        chk("ifid_pc", ifid_pc, m_p);
        chk("pc_plus1", ifid_pc_plus1, m_p1);
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    initial begin
        #1;
        step(2);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_pc", imem_addr, 0);
        rst_n = 1;
        step();
        chk("t1_e1_pc", ifid_pc, 16'h0000);
        chk("t1_e1_instr", ifid_instr, 16'h1000);
        chk("t1_e1_p1", ifid_pc_plus1, 16'h0001);
        step(2);
        chk("t1_e3_instr", ifid_instr, 16'h1002);
        step(2);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_addr", imem_addr, 16'd5);
            chk("t2_hold_pc", ifid_pc, 16'd4);
            chk("t2_hold_instr", ifid_instr, 16'h1004);
        end
        stall = 0;
        step();
        chk("t2_rel_instr", ifid_instr, 16'h1005);
        step();
        stall = 1; redirect_valid = 1; redirect_pc = 3;
        step();
        chk("t3_pc", imem_addr, 16'd3);
        chk("t3_bubble", ifid_valid, 0);
        stall = 0; redirect_valid = 0;
        step();
        chk("t3_instr", ifid_instr, 16'h1003);
        step(6);
        flush = 1;
        step();
        chk("t4_pc", imem_addr, 16'd10);
        chk("t4_bubble", ifid_valid, 0);
        flush = 0;
        step();
        chk("t4_refetch", ifid_pc, 16'd10);
        step(10);
        chk("t5_last", ifid_pc, 16'd20);
        chk("t5_pc", imem_addr, 16'd21);
        step();
        chk("t5_halted", halted, 1);
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            step();
            chk("t5_stay", halted, 1);
            chk("t5_stay_pc", imem_addr, 16'd21);
        end
        stall = 0; redirect_valid = 1; redirect_pc = 0;
        step();
        chk("t5_unhalt", halted, 0);
        redirect_valid = 0;
        step();
        chk("t5_restart", ifid_pc, 16'd0);
        step(8);
        stall = 1; rst_n = 0;
        step();
        chk("t6_pc", imem_addr, 16'd0);
        chk("t6_valid", ifid_valid, 0);
        chk("t6_instr", ifid_instr, 16'd0);
        stall = 0; rst_n = 1;
        step();
        chk("t6_instr2", ifid_instr, 16'h1000);
        for (int i = 0; i < 2000; i++) begin
            rst_n          = ($urandom_range(0, 99) >= 2);
            stall          = ($urandom_range(0, 99) < 30);
            flush          = ($urandom_range(0, 99) < 10);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = ($urandom_range(0, 9) == 0) ? 16'(-$urandom_range(1, 3))
                                                         : 16'($urandom_range(0, 24));
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage for the 16-bit IITB-RISC pipeline. Sits directly upstream of instruction_memory and feeds it.
- Owns the program counter and drives the ROM address. The ROM read is asynchronous, so instruction data returns in the same cycle.
- Captures the returned word into the IF/ID pipeline register.
- Handles decode-stage stalls, branch/jump redirects, flushes, and a halt when the PC runs past the last ROM word.

Parameters:
- PC_WIDTH, 16: width of PC and ROM address.
- INSTR_WIDTH, 16: instruction word width.
- RESET_PC, 16'h0000: PC value loaded on reset.
- ROM_DEPTH, 21: number of valid ROM words. Valid addresses are 0..ROM_DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_addr  out  PC_WIDTH  ROM address; equals pc_q combinationally.
- imem_data  in  INSTR_WIDTH  ROM read data for imem_addr, same cycle.
- stall  in  1  hazard-unit hold request from decode.
- flush  in  1  squash the IF/ID contents.
- redirect_valid  in  1  load a new PC (taken branch/jump).
- redirect_pc  in  PC_WIDTH  target PC.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- ifid_instr  out  INSTR_WIDTH  latched instruction.
- ifid_pc  out  PC_WIDTH  address of ifid_instr.
- ifid_pc_plus1  out  PC_WIDTH  ifid_pc+1, for link/return use.
- halted  out  1  fetch stopped: PC is out of ROM range.

Behaviour:
- Registers: pc_q, the IF/ID outputs, and a 2-state FSM (RUN, HALT). halted = (state==HALT), registered.
- PC is word-addressed; increment is +1 modulo 2^PC_WIDTH, so 0xFFFF wraps to 0x0000.
- Reset: with rst_n=0 at a rising edge, the next state is:
  - pc_q=RESET_PC, state=RUN;
  - ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus1=0, halted=0.
  - Reset wins over every other input, including mid-stall and in HALT.
- Per-edge priority when rst_n=1: redirect_valid > flush > stall > normal fetch.
- redirect_valid=1, in any state:
  - pc_q<=redirect_pc, ifid_valid<=0 (bubble), state<=RUN.
  - Other ifid_* fields hold their values.
  - Overrides a simultaneous stall or flush.
- flush=1, no redirect:
  - ifid_valid<=0, pc_q held, state unchanged.
  - The word at pc_q is refetched next cycle, so nothing is lost.
- stall=1, no redirect or flush: pc_q and all ifid_* hold their values. Latency through the stage is held for exactly the stall duration.
- Normal fetch in RUN with pc_q <= ROM_DEPTH-1:
  - ifid_instr<=imem_data, ifid_pc<=pc_q, ifid_pc_plus1<=pc_q+1;
  - ifid_valid<=1, pc_q<=pc_q+1.
  - Fetch-to-IF/ID latency is 1 cycle; throughput is 1 instruction per cycle.
- Normal fetch in RUN with pc_q >= ROM_DEPTH:
  - no latch; ifid_valid<=0, pc_q held, state<=HALT.
  - imem_data is ignored for this address.
- HALT:
  - pc_q held, ifid_valid<=0 each edge; stall and flush have no effect.
  - Exit only via reset, or via redirect (goes to RUN).
  - A redirect to an out-of-range target returns to HALT on the following edge.
- imem_addr is always driven from pc_q, including during stall and HALT.
- No X propagation: every register is assigned on reset.

Test Plan:
1. ROM[i]=16'h1000+i; hold rst_n=0 for 2 edges, then release.
   - Edge 1: ifid_valid=1, ifid_pc=0, ifid_instr=16'h1000, ifid_pc_plus1=1.
   - Edge 3: ifid_pc=2, ifid_instr=16'h1002.
2. With pc_q=5, assert stall for 3 cycles.
   - During stall: imem_addr=5, ifid_pc=4, ifid_instr=16'h1004, ifid_valid=1, all held.
   - First edge after release: ifid_pc=5, ifid_instr=16'h1005.
3. At pc_q=7, assert stall=1 and redirect_valid=1 with redirect_pc=3 together.
   - Next edge: pc_q=3, ifid_valid=0.
   - Following edge: ifid_pc=3, ifid_instr=16'h1003, ifid_valid=1.
4. At pc_q=10, pulse flush alone for 1 cycle.
   - Next edge: ifid_valid=0, pc_q=10.
   - Following edge: ifid_pc=10, ifid_valid=1.
5. Free-run to the end of the ROM.
   - Edge with pc_q=20: ifid_pc=20, pc_q=21.
   - Next edge: halted=1, ifid_valid=0, pc_q=21; stays there for 5 cycles even with stall toggling.
   - Redirect to 0: halted=0; next edge ifid_pc=0.
6. With pc_q=9 and stall=1, drive rst_n=0 for 1 edge.
   - All outputs and pc_q are at their reset values.
   - After release, fetch restarts from address 0 with ifid_instr=16'h1000.
